// File: rtl/mem_arbiter2.sv
// Two-port arbiter sharing one SRAM core interface; grants whole transactions and caps bursts.
// Define MEM_ARB_FIXED_PRIO_EN for fixed port0 priority; default build is round-robin.
module mem_arbiter2 #(
   parameter int ADDR_BITS = 22,
   parameter int MAX_BURST = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 m0_cs,
   input  logic                 m0_we,
   input  logic [ADDR_BITS-1:2] m0_addr,
   input  logic [3:0]           m0_sel,
   input  logic                 m0_burst,
   input  logic [31:0]          m0_din,
   output logic [31:0]          m0_dout,
   output logic                 m0_busy,
   output logic                 m0_ack,
   input  logic                 m1_cs,
   input  logic                 m1_we,
   input  logic [ADDR_BITS-1:2] m1_addr,
   input  logic [3:0]           m1_sel,
   input  logic                 m1_burst,
   input  logic [31:0]          m1_din,
   output logic [31:0]          m1_dout,
   output logic                 m1_busy,
   output logic                 m1_ack,
   output logic                 mem_cs,
   output logic                 mem_we,
   output logic [3:0]           mem_sel,
   output logic                 mem_burst,
   output logic [ADDR_BITS-1:2] mem_addr,
   output logic [31:0]          mem_din,
   input  logic [31:0]          mem_dout,
   input  logic                 mem_busy,
   input  logic                 mem_ack,
   output logic [1:0]           owner
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

   localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

   state_t     state;
   logic [7:0] beat_cnt;
   logic       last_owner;
   logic       own0;
   logic       own1;
   logic       last_beat;
   logic       preempt0;
   logic       preempt1;
   logic       pick1;

   assign own0 = (state == OWN0);
   assign own1 = (state == OWN1);

   // The beat that brings the count to the limit is the last one before a forced hand-over.
   assign last_beat = mem_ack && (beat_cnt >= BURST_LIM - 8'd1);
   assign preempt1  = last_beat && m0_cs;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign pick1    = m1_cs && !m0_cs;
   assign preempt0 = 1'b0;
`else
   assign pick1    = m1_cs && (!m0_cs || !last_owner);
   assign preempt0 = last_beat && m1_cs;
`endif

   always_comb begin
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_sel   = 4'b0000;
      mem_burst = 1'b0;
      mem_addr  = '0;
      mem_din   = 32'd0;
      if (own0) begin
         mem_cs    = m0_cs;
         mem_we    = m0_we;
         mem_sel   = m0_sel;
         mem_burst = m0_burst;
         mem_addr  = m0_addr;
         mem_din   = m0_din;
      end else if (own1) begin
         mem_cs    = m1_cs;
         mem_we    = m1_we;
         mem_sel   = m1_sel;
         mem_burst = m1_burst;
         mem_addr  = m1_addr;
         mem_din   = m1_din;
      end
   end

   assign m0_dout = mem_dout;
   assign m1_dout = mem_dout;
   assign m0_ack  = own0 && mem_ack;
   assign m1_ack  = own1 && mem_ack;
   assign m0_busy = !own0 || mem_busy;
   assign m1_busy = !own1 || mem_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 2'b00;
         beat_cnt   <= 8'd0;
         last_owner <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (!mem_busy && (m0_cs || m1_cs)) begin
                  last_owner <= pick1;
                  if (pick1) begin
                     state <= OWN1;
                     owner <= 2'b10;
                  end else begin
                     state <= OWN0;
                     owner <= 2'b01;
                  end
               end
            end
            OWN0, OWN1: begin
               if (mem_ack && (beat_cnt != BURST_LIM))
                  beat_cnt <= beat_cnt + 8'd1;
               if ((own0 && (!m0_cs || preempt0)) || (own1 && (!m1_cs || preempt1))) begin
                  state <= DRAIN;
                  owner <= 2'b00;
               end
            end
            DRAIN: begin
               // Owner change waits for the core to go idle so no beat straddles two owners.
               if (!mem_busy) begin
                  state    <= IDLE;
                  beat_cnt <= 8'd0;
               end
            end
            default: begin
               state <= IDLE;
               owner <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: vector table of single transactions plus tie, pre-emption,
// drain and asynchronous-reset sequences, with a per-port read-data scoreboard.
module tb_mem_arbiter2;

   localparam int AB = 22;

   logic          clk;
   logic          rst_n;
   logic          m0_cs, m0_we, m0_burst, m0_busy, m0_ack;
   logic [AB-1:2] m0_addr;
   logic [3:0]    m0_sel;
   logic [31:0]   m0_din, m0_dout;
   logic          m1_cs, m1_we, m1_burst, m1_busy, m1_ack;
   logic [AB-1:2] m1_addr;
   logic [3:0]    m1_sel;
   logic [31:0]   m1_din, m1_dout;
   logic          mem_cs, mem_we, mem_burst, mem_busy, mem_ack;
   logic [AB-1:2] mem_addr;
   logic [3:0]    mem_sel;
   logic [31:0]   mem_din, mem_dout;
   logic [1:0]    owner;

   logic        auto_core, man_ack, core_ack;
   logic [31:0] man_dout;
   int          core_lat;
   int          wcnt;

   int          n_pass;
   int          n_total;
   int          ackcnt [2];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

`ifdef MEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   typedef struct {
      bit            port;
      logic          we;
      logic [AB-1:2] addr;
      logic [3:0]    sel;
      logic          burst;
      logic [31:0]   din;
      int            lat;
      logic [1:0]    exp_owner;
   } vec_t;

   vec_t vecs [4];

   mem_arbiter2 #(.ADDR_BITS(AB), .MAX_BURST(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_cs(m0_cs), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
      .m0_burst(m0_burst), .m0_din(m0_din), .m0_dout(m0_dout),
      .m0_busy(m0_busy), .m0_ack(m0_ack),
      .m1_cs(m1_cs), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
      .m1_burst(m1_burst), .m1_din(m1_din), .m1_dout(m1_dout),
      .m1_busy(m1_busy), .m1_ack(m1_ack),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_sel(mem_sel), .mem_burst(mem_burst),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_busy(mem_busy), .mem_ack(mem_ack), .owner(owner)
   );

   function automatic logic [31:0] rd_data(input logic [AB-1:2] a);
      return 32'hC000_0000 ^ {12'h000, a};
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   // Simple core: acks core_lat cycles after cs, one beat at a time; read data derived from address.
   assign mem_ack  = auto_core ? core_ack : man_ack;
   assign mem_dout = auto_core ? rd_data(mem_addr) : man_dout;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt     <= 0;
         core_ack <= 1'b0;
      end else if (core_ack || !mem_cs) begin
         wcnt     <= 0;
         core_ack <= 1'b0;
      end else if (wcnt >= core_lat - 1) begin
         wcnt     <= 0;
         core_ack <= 1'b1;
      end else begin
         wcnt <= wcnt + 1;
      end
   end

   // Scoreboard side: every port ack must match the oldest expectation queued for that port.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m0_ack || m1_ack) check("ack_exclusive", 32'(m0_ack && m1_ack), 32'd0);
         if (m0_ack) begin
            ackcnt[0]++;
            check("ack0_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) check("dout0", m0_dout, q0.pop_front());
         end
         if (m1_ack) begin
            ackcnt[1]++;
            check("ack1_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) check("dout1", m1_dout, q1.pop_front());
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_port(input bit p, input logic cs, input logic we, input logic [AB-1:2] addr,
                             input logic [3:0] sel, input logic burst, input logic [31:0] din);
      if (p) begin
         m1_cs = cs; m1_we = we; m1_addr = addr; m1_sel = sel; m1_burst = burst; m1_din = din;
      end else begin
         m0_cs = cs; m0_we = we; m0_addr = addr; m0_sel = sel; m0_burst = burst; m0_din = din;
      end
   endtask

   task automatic set_cs(input bit p, input logic v);
      if (p) m1_cs = v;
      else m0_cs = v;
   endtask

   task automatic push_exp(input bit p, input logic [AB-1:2] a);
      if (p) q1.push_back(rd_data(a));
      else q0.push_back(rd_data(a));
   endtask

   task automatic wait_owner(input logic [1:0] exp, input string name, output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (owner == 2'b00 && lat < 40);
      check(name, 32'(owner), 32'(exp));
   endtask

   task automatic wait_ack(input bit p, input int target, input string name);
      int i;
      i = 0;
      while (ackcnt[p] < target && i < 60) begin
         tick();
         i++;
      end
      check(name, 32'(ackcnt[p]), 32'(target));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      q0.delete();
      q1.delete();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      vec_t v;
      int   lat, t, base, b0, b1, snap, snap1, first_p;
      bit   d0, d1;
      logic [1:0] tie_exp;

      n_pass = 0; n_total = 0;
      ackcnt[0] = 0; ackcnt[1] = 0;
      rst_n = 1'b0; auto_core = 1'b0; man_ack = 1'b1; man_dout = 32'h0BAD_F00D;
      core_lat = 1; mem_busy = 1'b0;
      drive_port(1'b0, 1'b1, 1'b1, 20'h12345, 4'hF, 1'b1, 32'h1111_1111);
      drive_port(1'b1, 1'b1, 1'b1, 20'h54321, 4'hF, 1'b1, 32'h2222_2222);

      vecs[0] = '{port:1'b0, we:1'b0, addr:20'h00100, sel:4'hF, burst:1'b0, din:32'h0000_0000, lat:3, exp_owner:2'b01};
      vecs[1] = '{port:1'b1, we:1'b1, addr:20'h02345, sel:4'b0011, burst:1'b0, din:32'hDEAD_BEEF, lat:2, exp_owner:2'b10};
      vecs[2] = '{port:1'b0, we:1'b1, addr:20'hFFFFF, sel:4'b1010, burst:1'b1, din:32'h1234_5678, lat:1, exp_owner:2'b01};
      vecs[3] = '{port:1'b1, we:1'b0, addr:20'h00000, sel:4'b0100, burst:1'b1, din:32'hCAFE_0001, lat:4, exp_owner:2'b10};

      // Held in reset with both ports requesting and a stray core ack.
      tick();
      check("rst_mem_cs", 32'(mem_cs), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_m0_busy", 32'(m0_busy), 32'd1);
      check("rst_m1_busy", 32'(m1_busy), 32'd1);
      check("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_sel_din", 32'(mem_sel) | mem_din, 32'd0);
      m0_cs = 1'b0; m1_cs = 1'b0; man_ack = 1'b0; auto_core = 1'b1;
      rst_n = 1'b1;
      tick();
      check("idle_owner", 32'(owner), 32'd0);
      check("idle_mem_cs", 32'(mem_cs), 32'd0);

      // Vector table: one single-beat transaction per record, the other port holding junk.
      for (int i = 0; i < 4; i++) begin
         v = vecs[i];
         core_lat = v.lat;
         push_exp(v.port, v.addr);
         drive_port(!v.port, 1'b0, !v.we, ~v.addr, ~v.sel, !v.burst, ~v.din);
         drive_port(v.port, 1'b1, v.we, v.addr, v.sel, v.burst, v.din);
         base = ackcnt[v.port];
         wait_owner(v.exp_owner, "vec_owner", lat);
         check("vec_grant_lat", 32'(lat), 32'd1);
         check("vec_mem_cs", 32'(mem_cs), 32'd1);
         check("vec_mem_addr", 32'(mem_addr), 32'(v.addr));
         check("vec_mem_sel", 32'(mem_sel), 32'(v.sel));
         check("vec_mem_din", mem_din, v.din);
         check("vec_mem_we_burst", 32'({mem_we, mem_burst}), 32'({v.we, v.burst}));
         check("vec_busy", 32'({m1_busy, m0_busy}), v.port ? 32'd1 : 32'd2);
         t = 0;
         while (ackcnt[v.port] == base && t < 20) begin
            tick();
            t++;
         end
         check("vec_ack_lat", 32'(t), 32'(v.lat));
         set_cs(v.port, 1'b0);
         tick();
         check("vec_drain", 32'({owner, mem_cs}), 32'd0);
         tick();
      end
      drive_port(1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b0, 32'd0);
      drive_port(1'b1, 1'b0, 1'b0, '0, 4'h0, 1'b0, 32'd0);

      // Simultaneous requests after reset, then a second tie while port1 still waits.
      do_reset();
      core_lat = 2;
      b0 = ackcnt[0]; b1 = ackcnt[1];
      push_exp(1'b0, 20'h00AA0);
      push_exp(1'b1, 20'h00BB0);
      drive_port(1'b0, 1'b1, 1'b0, 20'h00AA0, 4'hF, 1'b0, 32'd0);
      drive_port(1'b1, 1'b1, 1'b0, 20'h00BB0, 4'hF, 1'b0, 32'd0);
      wait_owner(2'b01, "tie_first", lat);
      wait_ack(1'b0, b0 + 1, "tie_first_ack");
      m0_cs = 1'b0;
      tick();
      push_exp(1'b0, 20'h00AA0);
      m0_cs = 1'b1;
      tie_exp = FIXED_PRIO ? 2'b01 : 2'b10;
      first_p = FIXED_PRIO ? 0 : 1;
      wait_owner(tie_exp, "tie_second", lat);
      wait_ack(1'(first_p), (first_p == 0) ? b0 + 2 : b1 + 1, "tie_second_ack");
      set_cs(1'(first_p), 1'b0);
      wait_owner((first_p == 0) ? 2'b10 : 2'b01, "tie_third", lat);
      wait_ack(1'(1 - first_p), (first_p == 0) ? b1 + 1 : b0 + 2, "tie_third_ack");
      set_cs(1'(1 - first_p), 1'b0);
      tick();
      tick();

      // Long port0 burst with port1 waiting.
      do_reset();
      core_lat = 1;
      b0 = ackcnt[0]; b1 = ackcnt[1];
      for (int k = 0; k < 40; k++) push_exp(1'b0, 20'h00400);
      drive_port(1'b0, 1'b1, 1'b0, 20'h00400, 4'hF, 1'b1, 32'd0);
      wait_owner(2'b01, "burst_owner0", lat);
      for (int k = 0; k < 3; k++) push_exp(1'b1, 20'h00800);
      drive_port(1'b1, 1'b1, 1'b0, 20'h00800, 4'hF, 1'b0, 32'd0);
      snap = -1; snap1 = -1; d0 = 1'b0; d1 = 1'b0;
      for (int c = 0; c < 2000 && !(d0 && d1 && owner == 2'b00); c++) begin
         tick();
         if (owner == 2'b10 && snap < 0) snap = ackcnt[0] - b0;
         if (!d0 && (ackcnt[0] - b0) >= 40) begin m0_cs = 1'b0; d0 = 1'b1; end
         if (!d1 && (ackcnt[1] - b1) >= 3) begin m1_cs = 1'b0; d1 = 1'b1; snap1 = ackcnt[0] - b0; end
      end
      check("burst_acks_before_switch", 32'(snap), FIXED_PRIO ? 32'd40 : 32'd16);
      check("burst_p0_at_p1_done", 32'(snap1), FIXED_PRIO ? 32'd40 : 32'd16);
      check("burst_p0_total", 32'(ackcnt[0] - b0), 32'd40);
      check("burst_p1_total", 32'(ackcnt[1] - b1), 32'd3);
      tick();

      // Release while the core stays busy for 5 cycles.
      core_lat = 2;
      b0 = ackcnt[0]; b1 = ackcnt[1];
      push_exp(1'b0, 20'h01000);
      drive_port(1'b0, 1'b1, 1'b0, 20'h01000, 4'hF, 1'b0, 32'd0);
      wait_owner(2'b01, "drain_owner0", lat);
      mem_busy = 1'b1;
      #1;
      check("owned_busy_high", 32'({m1_busy, m0_busy}), 32'd3);
      mem_busy = 1'b0;
      #1;
      check("owned_busy_low", 32'({m1_busy, m0_busy}), 32'd2);
      wait_ack(1'b0, b0 + 1, "drain_ack0");
      m0_cs = 1'b0;
      mem_busy = 1'b1;
      push_exp(1'b1, 20'h02000);
      drive_port(1'b1, 1'b1, 1'b0, 20'h02000, 4'hF, 1'b0, 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("drain_hold", 32'({owner, mem_cs, m1_busy}), 32'd1);
      end
      mem_busy = 1'b0;
      wait_owner(2'b10, "drain_regrant", lat);
      check("drain_exit_lat", 32'(lat), 32'd2);
      wait_ack(1'b1, b1 + 1, "drain_ack1");
      m1_cs = 1'b0;
      tick();
      tick();

      // Asynchronous reset in the middle of a beat.
      core_lat = 3;
      push_exp(1'b0, 20'h03000);
      drive_port(1'b0, 1'b1, 1'b1, 20'h03000, 4'h5, 1'b1, 32'h5555_AAAA);
      wait_owner(2'b01, "arst_owner", lat);
      tick();
      #1;
      rst_n = 1'b0;
      auto_core = 1'b0;
      man_ack = 1'b1;
      #1;
      check("arst_mem_cs", 32'({mem_cs, mem_we, mem_burst}), 32'd0);
      check("arst_mem_addr_din", 32'(mem_addr) | mem_din, 32'd0);
      check("arst_owner_now", 32'(owner), 32'd0);
      check("arst_busy_ack", 32'({m0_busy, m1_busy, m0_ack, m1_ack}), 32'hC);
      tick();
      tick();
      q0.delete();
      q1.delete();
      man_ack = 1'b0;
      auto_core = 1'b1;
      rst_n = 1'b1;
      b0 = ackcnt[0];
      push_exp(1'b0, 20'h03000);
      wait_owner(2'b01, "post_rst_owner", lat);
      check("post_rst_lat", 32'(lat), 32'd1);
      wait_ack(1'b0, b0 + 1, "post_rst_ack");
      m0_cs = 1'b0;
      tick();
      tick();

      check("sb_q0_empty", 32'(q0.size()), 32'd0);
      check("sb_q1_empty", 32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-port arbiter that shares one SRAM core memory interface (cs/we/addr/sel/burst/din/dout/busy/ack) between two requesters, e.g. the wishbone memory adapter and a video/DMA reader. It sits between the requesters and the SRAM core, in the core's clock domain. It grants whole transactions, keeps bursts atomic up to a beat limit, and switches owner only when the core is idle.

## Interface
Parameters:
- ADDR_BITS, 22, SRAM word-address width; addresses are [ADDR_BITS-1:2].
- MAX_BURST, 16, number of acks after which the owner is pre-empted if the other port is waiting; range 1..255.

Ports:
- clk  in  1  core clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- mN_cs  in  1  port N (N=0,1) request; held high until the last wanted ack.
- mN_we  in  1  port N write enable.
- mN_addr  in  ADDR_BITS-2  port N word address, valid per beat.
- mN_sel  in  4  port N byte selects.
- mN_burst  in  1  port N burst hint.
- mN_din  in  32  port N write data.
- mN_dout  out  32  read data; mem_dout broadcast to both ports.
- mN_busy  out  1  port N stalled: not granted, or mem_busy while granted.
- mN_ack  out  1  port N beat complete; mem_ack gated by grant.
- mem_cs, mem_we, mem_sel, mem_burst, mem_addr, mem_din  out  to core; muxed from the owner.
- mem_dout  in  32  core read data.
- mem_busy  in  1  core busy.
- mem_ack  in  1  core beat ack.
- owner  out  2  debug: 00 none, 01 port0, 10 port1.

## Operation
- FSM states: IDLE, OWN0, OWN1, DRAIN.
- IDLE:
  - No mem_cs is driven.
  - When some mN_cs is high and mem_busy is low, register the grant and move to OWNN on the next edge.
  - If both ports request, the winner is chosen by the priority rule (see Configuration).
- OWNN:
  - mem_* is driven combinationally from port N.
  - mem_ack is routed to mN_ack only; the other port's ack stays 0.
  - beat_cnt (8 bit) increments on each mem_ack and saturates at MAX_BURST.
- Leaving OWNN, release: on the first cycle mN_cs is low, go to DRAIN.
- Leaving OWNN, pre-emption:
  - Condition: beat_cnt == MAX_BURST, the other port's cs is high, and the cycle of mem_ack is done.
  - Force mem_cs = 0 and mem_burst = 0 from the following cycle, then go to DRAIN.
  - The owner keeps its cs high. It sees no ack and simply waits for re-grant.
- DRAIN:
  - mem_cs = 0.
  - Wait until mem_busy is low, then go to IDLE.
  - beat_cnt clears on entry to IDLE.
- The last_owner flag updates when a grant is issued.
- A requester dropping cs mid-burst is legal; it releases as above.

## Timing
- Reset values: state IDLE, all mem_* outputs 0, mN_ack 0, mN_busy 1, owner 00, beat_cnt 0, last_owner port1. Port0 therefore wins the first tie.
- Arbitration latency is 1 cycle: cs seen in IDLE at edge k, mem_cs asserted after edge k+1.
- Minimum switch gap between owners is 2 cycles (OWN → DRAIN → IDLE → OWN) when mem_busy is already low. It is longer while mem_busy stays high.
- mN_ack and mN_dout are combinational from the core, with zero added latency.
- Simultaneous release and new request in IDLE: the grant follows the priority rule. A port that released is not excluded from winning.
- rst_n asserted mid-transaction: immediate return to IDLE, all outputs at reset values. An in-flight core beat is abandoned and its ack is ignored.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined:
  - Port0 always wins ties.
  - Pre-emption applies only to port1. Port0 bursts are never pre-empted.
- Not defined:
  - Round-robin: ties go to the port that is not last_owner.
  - Pre-emption applies to both ports symmetrically.

## Test plan
- Single port0 read at addr 0x100, core acks after 3 cycles → mem_cs high 1 cycle after m0_cs, one m0_ack, m1_ack stays 0, then DRAIN → IDLE.
- Both ports assert cs in the same cycle after reset → port0 is granted first. In round-robin mode the next tie goes to port1.
- Port0 holds cs for 40 beats with MAX_BURST=16 while port1 waits → port0 gets exactly 16 acks, then port1 is granted. Round-robin: port0 resumes after port1 releases. Fixed-prio: port0 is never cut off.
- Owner releases while mem_busy stays high for 5 cycles → arbiter stays in DRAIN for 5 cycles with no mem_cs to either port.
- rst_n pulsed low mid-burst → all outputs return to reset values asynchronously, and the first request after release is granted normally.
- Port1 write with sel=4'b0011 and data 0xDEADBEEF → mem_sel, mem_din and mem_addr exactly mirror port1 while owner=10, and port0 inputs have no effect.
